// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage sitting between the program counter and decode.
// On a fetch request it samples the PC and runs one req/gnt/rvalid transaction
// on the instruction-memory port. It then captures the returned word and its
// address, and pulses the PC enable so the PC advances to PCNext.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When defined, a PC with
// non-zero low bits faults instead of going to memory.

package riscv_pkg;
  localparam int unsigned XLEN = 32;
endpackage

module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0]     RESET_INSTR = 32'h0000_0013,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [XLEN-1:0] PC_i,
  input  logic            fetch_req_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     Instr_o,
  output logic [XLEN-1:0] OldPC_o,
  output logic            instr_valid_o,
  output logic            pc_en_o,
  output logic            busy_o,
  output logic            fault_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state;

  // Busy is the only output decoded from state. It is high for the whole
  // transaction, including the RESP cycle.
  assign busy_o = (state != IDLE);

  // Fetch FSM with registered outputs. imem_addr_o doubles as the latched
  // fetch address, so it stays stable from REQ until the response is captured.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values. Blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      imem_req_o    <= 1'b0;
      imem_addr_o   <= RESET_PC;
      Instr_o       <= RESET_INSTR;
      OldPC_o       <= RESET_PC;
      instr_valid_o <= 1'b0;
      pc_en_o       <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      // Completion strobes are single-cycle. They are re-asserted only on the
      // transition into RESP.
      instr_valid_o <= 1'b0;
      pc_en_o       <= 1'b0;
      fault_o       <= 1'b0;

      case (state)
        IDLE: begin
          if (fetch_req_i) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (PC_i[1:0] != 2'b00) begin
              // Misaligned PC: no memory traffic. Report the faulting
              // address and keep the last good instruction.
              OldPC_o <= PC_i;
              fault_o <= 1'b1;
              state   <= RESP;
            end else
`endif
            begin
              imem_addr_o <= PC_i;
              imem_req_o  <= 1'b1;
              state       <= REQ;
            end
          end
        end

        REQ: begin
          // Request held with no timeout. Any rvalid seen here is ignored.
          if (imem_gnt_i) begin
            imem_req_o <= 1'b0;
            state      <= WAIT;
          end
        end

        WAIT: begin
          if (imem_rvalid_i) begin
            Instr_o       <= imem_rdata_i;
            OldPC_o       <= imem_addr_o;
            instr_valid_o <= 1'b1;
            pc_en_o       <= 1'b1;
            state         <= RESP;
          end
        end

        RESP: begin
          // A fetch_req_i seen here is dropped. The next fetch may start in
          // the IDLE cycle that follows.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter in the multicycle core.
- On a fetch request from the control FSM it does the following:
  - samples the current PC;
  - runs a req/gnt/rvalid transaction on the instruction-memory port;
  - latches the returned word into the instruction register and the fetch address into OldPC;
  - pulses the PC enable so the PC register advances to PCNext.
- Outputs feed decode and the PC-relative (branch/JAL/AUIPC) datapath.

Parameters:
- RESET_INSTR, 32'h0000_0013, instruction register value after reset (ADDI x0,x0,0 = NOP).
- RESET_PC, 32'h8000_0000, OldPC value after reset; matches the PC reset vector.
- XLEN is taken from riscv_pkg and is not a module parameter.

Ports:
- clk_i  input  1  core clock; all state changes on posedge.
- rstn_i  input  1  reset, synchronous, active-low.
- PC_i  input  XLEN  current PC from the program counter.
- fetch_req_i  input  1  start-fetch strobe from the control FSM.
- imem_req_o  output  1  instruction-memory request.
- imem_addr_o  output  XLEN  instruction-memory address.
- imem_gnt_i  input  1  memory accepted the request.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  32  read data.
- Instr_o  output  32  instruction register.
- OldPC_o  output  XLEN  address of Instr_o.
- instr_valid_o  output  1  one-cycle pulse: Instr_o/OldPC_o updated.
- pc_en_o  output  1  one-cycle pulse to the PC enable.
- busy_o  output  1  fetch in progress (state != IDLE).
- fault_o  output  1  misaligned-fetch pulse (see Optional Feature).

Behaviour:
- Reset (rstn_i low at a posedge) puts the block in this state:
  - state = IDLE;
  - Instr_o = RESET_INSTR, OldPC_o = RESET_PC;
  - imem_addr_o = RESET_PC;
  - imem_req_o, instr_valid_o, pc_en_o, busy_o, fault_o = 0.
- Reset mid-transaction aborts immediately. A later rvalid belonging to the aborted transaction is ignored because the FSM is in IDLE.
- All outputs are registered; busy_o is the only one decoded from state.
- FSM states are IDLE, REQ, WAIT, RESP.
- IDLE:
  - fetch_req_i = 1: latch PC_i into the address register, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - imem_req_o = 1; imem_addr_o holds the latched address, stable until gnt.
  - imem_gnt_i = 1: go to WAIT, imem_req_o = 0 from the next cycle.
  - The request is held indefinitely with no timeout.
- WAIT:
  - imem_rvalid_i = 1 does the following at the next posedge:
    - Instr_o <= imem_rdata_i;
    - OldPC_o <= address register;
    - go to RESP.
  - Otherwise stay in WAIT.
- RESP:
  - instr_valid_o = 1 and pc_en_o = 1 for exactly this cycle.
  - Go to IDLE next cycle.
  - fetch_req_i in RESP is ignored.
- rvalid is only sampled in WAIT. rvalid in IDLE or REQ (including the same cycle as gnt) is ignored.
- fetch_req_i asserted while busy_o = 1 is ignored and is not queued.
- Latency:
  - fetch_req at cycle 0; REQ at cycle 1.
  - With gnt in cycle 1 and rvalid in cycle 2, RESP is at cycle 3.
  - Minimum 3 cycles from fetch_req to instr_valid_o/pc_en_o.
- Back-to-back fetches: a new fetch_req_i is accepted in the cycle after RESP (IDLE), giving a 4-cycle minimum issue interval.
- Instr_o and OldPC_o hold their values between completions. They change only on an rvalid capture or on reset.
- Address width: the full XLEN PC is passed through; no truncation.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined: if PC_i[1:0] != 2'b00 when fetch_req_i is accepted in IDLE:
  - no memory request is issued;
  - FSM goes IDLE -> RESP with fault_o = 1 for the RESP cycle;
  - instr_valid_o = 0 and pc_en_o = 0;
  - Instr_o is unchanged; OldPC_o <= faulting PC_i;
  - next cycle the FSM returns to IDLE.
- Not defined: fault_o is tied 0; the PC is passed to imem_addr_o unmodified regardless of its low bits.

Test Plan:
- Reset: hold rstn_i = 0 for 2 cycles -> Instr_o = 32'h0000_0013, OldPC_o = 32'h8000_0000, all strobes 0, busy_o = 0.
- Zero-wait fetch: PC_i = 32'h8000_0000, fetch_req pulse at cycle 0, gnt at cycle 1, rvalid with rdata = 32'h0050_0093 at cycle 2 -> at cycle 3 Instr_o = 32'h0050_0093, OldPC_o = 32'h8000_0000, instr_valid_o = pc_en_o = 1 for one cycle.
- Stalled memory: gnt delayed 3 cycles and rvalid delayed 2 more cycles -> imem_req_o and imem_addr_o stay stable until gnt, exactly one pc_en_o pulse, busy_o high throughout.
- Ignored request: fetch_req_i held high for the whole transaction at PC 32'h8000_0004 -> exactly one memory request and one pc_en_o pulse; a new request starts only at the IDLE cycle after RESP.
- Reset mid-fetch: rstn_i low in WAIT, then a stray rvalid with rdata = 32'hDEAD_BEEF -> Instr_o stays 32'h0000_0013, no instr_valid_o.
- FETCH_MISALIGN_CHECK_EN: PC_i = 32'h8000_0002 with fetch_req -> imem_req_o never asserts, fault_o = 1 for one cycle, OldPC_o = 32'h8000_0002, pc_en_o = 0. Without the macro the same stimulus issues a request at 32'h8000_0002.
